mem_port_arbiter: RTL and testbench

- Shares the CPU's single unified memory port between two requesters: instruction fetch (IF) and load/store unit (LS).
- Sits between the CPU core datapath and the memory model, and is instantiated inside the CPU top.
- Uses round-robin arbitration, a fixed-latency memory read path, and per-requester grant/response handshakes.
- Allows back-to-back transactions without idle bubbles after a read response.

---
 rtl/cpu_mem_pkg.sv | 24 ++
 rtl/mem_port_arbiter_rr_pick2.sv | 30 +++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared types and widths for the CPU memory port arbiter
//
// Purpose: FSM state and requester id enums plus default bus widths used by
//          mem_port_arbiter and rr_pick2.
// Ports:   none (package).

package cpu_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rtl/mem_port_arbiter_rr_pick2.sv - two-way round-robin selector
//
// Purpose: combinational pick between IF (req[0]) and LS (req[1]); a lone
//          requester always wins, on a tie the one not granted last wins.
// Ports:
//   req    in  2  request vector, bit 0 = IF, bit 1 = LS
//   last   in  1  requester granted most recently
//   valid  out 1  at least one request present
//   winner out 1  selected requester (meaningful when valid)

module rr_pick2
  import cpu_mem_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  output logic       valid,
  output req_id_t    winner
);

  always_comb begin
    valid  = |req;
    winner = REQ_IF;
    if (req == 2'b10) begin
      winner = REQ_LS;
    end else if (req == 2'b11) begin
      winner = (last == REQ_IF) ? REQ_LS : REQ_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter for the CPU unified memory port
//
// Purpose: shares one fixed-latency memory port between instruction fetch (IF)
//          and load/store (LS). All outputs are registered.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   if_req/if_addr                    IF read request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata         IF grant pulse, response pulse, data
//   ls_req/ls_we/ls_addr/ls_wdata     LS request, held until ls_gnt
//   ls_gnt/ls_rvalid/ls_rdata         LS grant pulse, read response, data
//   mem_en/mem_we/mem_addr/mem_wdata  memory command (mem_en one cycle)
//   mem_rdata                         read data, valid MEM_LAT cycles after mem_en

module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W  = cpu_mem_pkg::ADDR_W,
  parameter int DATA_W  = cpu_mem_pkg::DATA_W,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LAT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);

  arb_state_t       r_state;
  req_id_t          r_last;
  req_id_t          r_owner;
  logic             r_we;
  logic [LAT_W-1:0] r_lat_cnt;

  logic             w_pick_valid;
  req_id_t          w_winner;

  rr_pick2 u_pick (
    .req    ({ls_req, if_req}),
    .last   (r_last),
    .valid  (w_pick_valid),
    .winner (w_winner)
  );

  // Outputs are registered, so the command and grant are loaded on the edge
  // that enters ISSUE and appear during the ISSUE cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last    <= REQ_LS;
      r_owner   <= REQ_IF;
      r_we      <= 1'b0;
      r_lat_cnt <= '0;
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_gnt    <= 1'b0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;

      unique case (r_state)
        IDLE, RESP: begin
          if (w_pick_valid) begin
            r_state <= ISSUE;
            r_owner <= w_winner;
            r_last  <= w_winner;
            mem_en  <= 1'b1;
            if (w_winner == REQ_IF) begin
              if_gnt    <= 1'b1;
              r_we      <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end else begin
              ls_gnt    <= 1'b1;
              r_we      <= ls_we;
              mem_we    <= ls_we;
              mem_addr  <= ls_addr;
              mem_wdata <= ls_wdata;
            end
          end else begin
            r_state <= IDLE;
          end
        end

        ISSUE: begin
          if (r_we) begin
            r_state <= IDLE;
          end else begin
            // WAIT lasts MEM_LAT cycles; the last one (count 0) is the cycle
            // in which mem_rdata is valid.
            r_lat_cnt <= LAT_W'(MEM_LAT - 1);
            r_state   <= WAIT;
          end
        end

        WAIT: begin
          if (r_lat_cnt == '0) begin
            r_state <= RESP;
            if (r_owner == REQ_IF) begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end else begin
              ls_rvalid <= 1'b1;
              ls_rdata  <= mem_rdata;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;

  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid;
  logic [31:0] if_rdata, ls_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        if_req_b, ls_req_b, ls_we_b;
  logic [31:0] if_addr_b, ls_addr_b, ls_wdata_b;
  logic        if_gnt_b, if_rvalid_b, ls_gnt_b, ls_rvalid_b;
  logic [31:0] if_rdata_b, ls_rdata_b;
  logic        mem_en_b, mem_we_b;
  logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_lat1 (
    .clk(clk), .rst(rst),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b),
    .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
    .ls_req(ls_req_b), .ls_we(ls_we_b), .ls_addr(ls_addr_b), .ls_wdata(ls_wdata_b),
    .ls_gnt(ls_gnt_b), .ls_rvalid(ls_rvalid_b), .ls_rdata(ls_rdata_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: read data is valid only in the cycle MEM_LAT after mem_en;
  // every other cycle shows a poison pattern.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_5A5A);
  endfunction

  logic [32:0] pipe_a [2];
  logic [32:0] pipe_b;
  always @(posedge clk) begin
    pipe_a[0] <= {mem_en & ~mem_we, mem_addr};
    pipe_a[1] <= pipe_a[0];
    pipe_b    <= {mem_en_b & ~mem_we_b, mem_addr_b};
  end
  assign mem_rdata   = (pipe_a[1][32] === 1'b1) ? mem_val(pipe_a[1][31:0]) : 32'hBAD0_BAD0;
  assign mem_rdata_b = (pipe_b[32] === 1'b1)    ? mem_val(pipe_b[31:0])    : 32'hBAD0_BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we}, 64'h0);
    chk({tag, "_cmd"}, {mem_addr, mem_wdata}, 64'h0);
    chk({tag, "_rd"},  {if_rdata, ls_rdata}, 64'h0);
  endtask

  // Advance one cycle, check {if_gnt, ls_gnt, if_rvalid, ls_rvalid}, and
  // drop a request once it has been granted.
  task automatic step(input string tag, input logic [3:0] exp);
    tick();
    chk(tag, {if_gnt, ls_gnt, if_rvalid, ls_rvalid}, exp);
    if (if_gnt) if_req = 1'b0;
    if (ls_gnt) ls_req = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int ng;
    int gap;

    if_req_b = 0; if_addr_b = 0; ls_req_b = 0; ls_we_b = 0;
    ls_addr_b = 0; ls_wdata_b = 0;

    // Reset with both requests high, then tie: IF first, LS after IF response.
    rst = 1; if_req = 1; ls_req = 1; ls_we = 0;
    if_addr = 32'h40; ls_addr = 32'h80; ls_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_zero("reset");
    end
    rst = 0;
    step("tie_c1", 4'b1000);
    chk("tie_c1_cmd", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 32'h40});
    step("tie_c2", 4'b0000);
    chk("tie_c2_en", mem_en, 1'b0);
    step("tie_c3", 4'b0000);
    step("tie_c4", 4'b0010);
    chk("tie_c4_data", if_rdata, 32'hDEAD_BEEF);
    step("tie_c5", 4'b0100);
    chk("tie_c5_cmd", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 32'h80});
    step("tie_c6", 4'b0000);
    step("tie_c7", 4'b0000);
    step("tie_c8", 4'b0001);
    chk("tie_c8_data", {if_rdata, ls_rdata}, {32'hDEAD_BEEF, 32'h5A5A_5ADA});
    step("tie_c9", 4'b0000);

    // Lone IF read.
    if_req = 1; if_addr = 32'hC0;
    step("ifrd_c1", 4'b1000);
    chk("ifrd_c1_cmd", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 32'hC0});
    step("ifrd_c2", 4'b0000);
    step("ifrd_c3", 4'b0000);
    step("ifrd_c4", 4'b0010);
    chk("ifrd_c4_data", {if_rdata, ls_rdata}, {32'h5A5A_5A9A, 32'h5A5A_5ADA});
    step("ifrd_c5", 4'b0000);

    // LS write while IF is pending; last grant was IF so LS wins.
    ls_req = 1; ls_we = 1; ls_addr = 32'h100; ls_wdata = 32'h1234_5678;
    if_req = 1; if_addr = 32'h40;
    step("lswr_c1", 4'b0100);
    chk("lswr_c1_cmd", {mem_en, mem_we, mem_addr}, {1'b1, 1'b1, 32'h100});
    chk("lswr_c1_wdata", mem_wdata, 32'h1234_5678);
    ls_we = 0;
    step("lswr_c2", 4'b0000);
    chk("lswr_c2_en", mem_en, 1'b0);
    step("lswr_c3", 4'b1000);
    chk("lswr_c3_cmd", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 32'h40});
    step("lswr_c4", 4'b0000);
    step("lswr_c5", 4'b0000);
    step("lswr_c6", 4'b0010);
    chk("lswr_c6_data", {if_rdata, ls_rdata}, {32'hDEAD_BEEF, 32'h5A5A_5ADA});

    // Fairness after a fresh reset: strict IF/LS alternation, 4-cycle spacing.
    rst = 1;
    tick();
    rst = 0;
    chk_zero("rst_fair");
    if_req = 1; if_addr = 32'h200; ls_req = 1; ls_we = 0; ls_addr = 32'h300;
    ng = 0;
    gap = 0;
    for (int c = 0; c < 60 && ng < 8; c++) begin
      tick();
      gap++;
      chk("fair_excl", {if_gnt & ls_gnt, if_rvalid & ls_rvalid}, 2'b00);
      if (if_gnt || ls_gnt) begin
        chk("fair_order", {if_gnt, ls_gnt}, (ng % 2 == 0) ? 2'b10 : 2'b01);
        if (ng > 0) chk("fair_gap", gap, 4);
        gap = 0;
        ng++;
        if (if_gnt) if_req = 1'b0;
        if (ls_gnt) ls_req = 1'b0;
      end
      if (if_rvalid) begin if_req = 1'b1; if_addr = if_addr + 4; end
      if (ls_rvalid) begin ls_req = 1'b1; ls_addr = ls_addr + 4; end
    end
    chk("fair_count", ng, 8);

    // Reset during WAIT drops the read; a following read completes.
    rst = 1; if_req = 0; ls_req = 0;
    tick();
    rst = 0;
    chk_zero("rst_wait_pre");
    if_req = 1; if_addr = 32'h48;
    step("rw_c1", 4'b1000);
    rst = 1;
    tick();
    rst = 0;
    tick();
    chk_zero("rw_c3");
    step("rw_c4", 4'b0000);
    step("rw_c5", 4'b0000);
    step("rw_c6", 4'b0000);
    if_req = 1; if_addr = 32'h4C;
    step("rw2_c1", 4'b1000);
    step("rw2_c2", 4'b0000);
    step("rw2_c3", 4'b0000);
    step("rw2_c4", 4'b0010);
    chk("rw2_c4_data", if_rdata, 32'h5A5A_5A16);

    // MEM_LAT = 1 instance: IF read response in cycle 3.
    if_req_b = 1; if_addr_b = 32'h40;
    tick();
    chk("lat1_c1", {if_gnt_b, ls_gnt_b, if_rvalid_b, ls_rvalid_b, mem_en_b}, 5'b10001);
    if_req_b = 0;
    tick();
    chk("lat1_c2", {if_gnt_b, ls_gnt_b, if_rvalid_b, ls_rvalid_b, mem_en_b}, 5'b00000);
    tick();
    chk("lat1_c3", {if_gnt_b, ls_gnt_b, if_rvalid_b, ls_rvalid_b, mem_en_b}, 5'b00100);
    chk("lat1_c3_data", if_rdata_b, 32'hDEAD_BEEF);
    tick();
    chk("lat1_c4", if_rvalid_b, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
